fcmp_unit: RTL and testbench

- Pipelined floating-point compare execution unit in the FPU.
- Accepts feq/flt/fle ops from the FPU issue stage with a valid/ready handshake.
- Classifies and compares two IEEE-754 single operands, then returns a 0/1 integer result with its destination tag to the integer writeback arbiter.
- Fixed 2-cycle latency, full throughput, backpressure-safe, flushable.

---
 rtl/fpu_pkg.sv | 20 ++
 rtl/fcmp_classify.sv | 20 ++
 rtl/fcmp_unit.sv | 124 ++++++++++++
 tb/tb_fcmp_unit.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU compare path.
// Class encoding is ordered so that a plain numeric compare gives NEG < ZERO < POS.
package fpu_pkg;

  typedef enum logic [1:0] {
    FEQ  = 2'd0,
    FLT  = 2'd1,
    FLE  = 2'd2,
    FRSV = 2'd3
  } fcmp_op_t;

  typedef enum logic [1:0] {
    NEG  = 2'd0,
    ZERO = 2'd1,
    POS  = 2'd2
  } fclass_t;

  localparam logic [7:0] EXP_ZERO = 8'd0;

endpackage

// File: rtl/fcmp_classify.sv
// Sorts one single-precision operand into NEG / ZERO / POS.
// Denormals have a zero exponent, so they land in ZERO together with both signed zeros.
module fcmp_classify
  import fpu_pkg::*;
(
  input  logic [31:0] i_x,
  output fclass_t     o_class
);

  always_comb begin
    if (i_x[30:23] == EXP_ZERO) begin
      o_class = ZERO;
    end else if (i_x[31]) begin
      o_class = NEG;
    end else begin
      o_class = POS;
    end
  end

endmodule

// File: rtl/fcmp_unit.sv
// Two-stage floating-point compare unit (feq/flt/fle) with valid/ready on both sides.
// S1 registers operand classes and magnitude relations; S2 resolves the op into a 0/1 result.
module fcmp_unit
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic             busy
);

  logic             r_s1Valid;
  fcmp_op_t         r_s1Op;
  logic [TAG_W-1:0] r_s1Tag;
  fclass_t          r_s1Class1;
  fclass_t          r_s1Class2;
  logic             r_s1MagLe;
  logic             r_s1MagGe;
  logic             r_s1BitsEq;

  logic             r_outValid;
  logic [31:0]      r_outResult;
  logic [TAG_W-1:0] r_outTag;
  logic             r_outIllegal;

  fclass_t w_class1;
  fclass_t w_class2;
  logic    w_s2Load;
  logic    w_accept;
  logic    w_le;
  logic    w_eq;
  logic    w_res;

  fcmp_classify u_classify1 (.i_x(in_x1), .o_class(w_class1));
  fcmp_classify u_classify2 (.i_x(in_x2), .o_class(w_class2));

  // S1 only moves when S2 takes its contents, so one ready term covers both stages.
  assign w_s2Load = ~r_outValid | out_ready;
  assign in_ready = ~flush & (~r_s1Valid | w_s2Load);
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_le  = 1'b0;
    w_res = 1'b0;
    if (r_s1Class1 != r_s1Class2) begin
      w_le = (r_s1Class1 < r_s1Class2);
    end else begin
      case (r_s1Class1)
        ZERO:    w_le = 1'b1;
        POS:     w_le = r_s1MagLe;
        NEG:     w_le = r_s1MagGe;
        default: w_le = 1'b0;
      endcase
    end
    w_eq = ((r_s1Class1 == ZERO) & (r_s1Class2 == ZERO)) | r_s1BitsEq;
    case (r_s1Op)
      FEQ:     w_res = w_eq;
      FLT:     w_res = w_le & ~w_eq;
      FLE:     w_res = w_le;
      default: w_res = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid    <= 1'b0;
      r_s1Op       <= FEQ;
      r_s1Tag      <= '0;
      r_s1Class1   <= ZERO;
      r_s1Class2   <= ZERO;
      r_s1MagLe    <= 1'b0;
      r_s1MagGe    <= 1'b0;
      r_s1BitsEq   <= 1'b0;
      r_outValid   <= 1'b0;
      r_outResult  <= '0;
      r_outTag     <= '0;
      r_outIllegal <= 1'b0;
    end else if (flush) begin
      r_s1Valid  <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      if (w_s2Load) begin
        r_outValid <= r_s1Valid;
        if (r_s1Valid) begin
          r_outResult  <= {31'd0, w_res};
          r_outTag     <= r_s1Tag;
          r_outIllegal <= (r_s1Op == FRSV);
        end
      end
      if (~r_s1Valid | w_s2Load) begin
        r_s1Valid <= w_accept;
        if (w_accept) begin
          r_s1Op     <= fcmp_op_t'(in_op);
          r_s1Tag    <= in_tag;
          r_s1Class1 <= w_class1;
          r_s1Class2 <= w_class2;
          r_s1MagLe  <= (in_x1[30:0] <= in_x2[30:0]);
          r_s1MagGe  <= (in_x2[30:0] <= in_x1[30:0]);
          r_s1BitsEq <= (in_x1 == in_x2);
        end
      end
    end
  end

  assign out_valid   = r_outValid;
  assign out_result  = r_outResult;
  assign out_tag     = r_outTag;
  assign out_illegal = r_outIllegal;
  assign busy        = r_s1Valid | r_outValid;

endmodule

// File: tb/tb_fcmp_unit.sv
// Bench for fcmp_unit: directed cases, stalls, flush, reset and randomized traffic
// checked against a signed-key model of the compare ordering.
module tb_fcmp_unit;
  import fpu_pkg::*;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal, busy;
  logic [1:0]       in_op;
  logic [31:0]      in_x1, in_x2, out_result;
  logic [TAG_W-1:0] in_tag, out_tag;

  typedef struct packed {
    logic [31:0]      result;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } res_t;

  int   testsRun = 0;
  int   testsFailed = 0;
  int   stabilityErrors = 0;
  res_t pendQ[$];
  res_t obsQ[$];
  res_t expQ[$];
  logic holdPending = 1'b0;
  res_t heldOut;

  fcmp_unit #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_illegal(out_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  // Map an operand onto a signed integer whose natural order is the compare order.
  function automatic longint keyOf(logic [31:0] x);
    longint mag;
    mag = longint'({33'd0, x[30:0]});
    if (x[30:23] == 8'd0) return 0;
    return x[31] ? -mag : mag;
  endfunction

  function automatic res_t refModel(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                                    logic [TAG_W-1:0] tag);
    res_t   r;
    longint ka;
    longint kb;
    logic   v;
    ka = keyOf(a);
    kb = keyOf(b);
    case (op)
      2'd0:    v = (ka == kb);
      2'd1:    v = (ka < kb);
      2'd2:    v = (ka <= kb);
      default: v = 1'b0;
    endcase
    r.result  = {31'd0, v};
    r.tag     = tag;
    r.illegal = (op == 2'd3);
    return r;
  endfunction

  // Tracks in-flight ops, pairs each output handshake with its expected value and watches hold stability.
  always @(negedge clk) begin : monitor
    res_t cur;
    res_t bad;
    cur = {out_result, out_tag, out_illegal};
    if (holdPending && (!out_valid || cur !== heldOut)) stabilityErrors++;
    holdPending = out_valid && !out_ready && !rst && !flush;
    heldOut = cur;
    if (!rst && out_valid && out_ready) begin
      obsQ.push_back(cur);
      if (pendQ.size() > 0) begin
        expQ.push_back(pendQ.pop_front());
      end else begin
        bad = '1;
        expQ.push_back(bad);
      end
    end
    if (rst || flush) pendQ.delete();
    else if (in_valid && in_ready) pendQ.push_back(refModel(in_op, in_x1, in_x2, in_tag));
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    in_valid = 1'b0;
    flush    = 1'b0;
    in_op    = 2'd0;
    in_x1    = '0;
    in_x2    = '0;
    in_tag   = '0;
  endtask

  task automatic driveOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_x1    = a;
    in_x2    = b;
    in_tag   = tag;
  endtask

  function automatic logic [31:0] genOperand(logic [31:0] other);
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       return {r[31], 8'd0, r[22:0]};
      1:       return other;
      2:       return {~other[31], other[30:0]};
      3:       return other + 32'd1;
      default: return r;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    setIdle();
    out_ready = 1'b1;
    repeat (3) tick();
    testsRun++;
    if (out_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_out_valid: got %b, want 0", out_valid);
    end
    testsRun++;
    if (out_result !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_out_result: got %h, want 0", out_result);
    end
    testsRun++;
    if (out_tag !== '0 || out_illegal !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_tag_illegal: got tag %0d ill %b, want 0/0", out_tag, out_illegal);
    end
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_busy: got %b, want 0", busy);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [1:0]  opT [13] = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1,
                              2'd2, 2'd2, 2'd1, 2'd3};
    logic [31:0] aT [13] = '{32'h3F800000, 32'h3F800000, 32'h3F800000,
                             32'h80000000, 32'h80000000, 32'h80000000,
                             32'h00000001, 32'h00000001, 32'h00000001,
                             32'hC0000000, 32'hBF800000, 32'hBF800000, 32'h3F800000};
    logic [31:0] bT [13] = '{32'h40000000, 32'h40000000, 32'h40000000,
                             32'h00000000, 32'h00000000, 32'h00000000,
                             32'h00000000, 32'h00000000, 32'h00000000,
                             32'hBF800000, 32'hC0000000, 32'h3F800000, 32'h3F800000};
    logic        resT [13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                               1'b1, 1'b0, 1'b1, 1'b0};
    res_t exp;
    res_t got;
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      driveOp(opT[i], aT[i], bT[i], TAG_W'(3 + i));
      tick();
      in_valid = 1'b0;
      testsRun++;
      if (out_valid !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL directed_early_%0d: out_valid got %b, want 0", i, out_valid);
      end
      tick();
      exp = {{31'd0, resT[i]}, TAG_W'(3 + i), (i == 12)};
      got = {out_result, out_tag, out_illegal};
      testsRun++;
      if (out_valid !== 1'b1 || got !== exp) begin
        testsFailed++;
        $display("[TB] FAIL directed_%0d: got valid %b res %h tag %0d ill %b, want valid 1 res %h tag %0d ill %b",
                 i, out_valid, got.result, got.tag, got.illegal, exp.result, exp.tag, exp.illegal);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    obsQ.delete();
    expQ.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_x1 = $urandom;
      driveOp(2'($urandom_range(0, 2)), in_x1, genOperand(in_x1), TAG_W'(c));
      @(negedge clk);
      testsRun++;
      if (in_ready !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL b2b_in_ready_%0d: got %b, want 1", c, in_ready);
      end
      if (c >= 2) begin
        testsRun++;
        if (out_valid !== 1'b1) begin
          testsFailed++;
          $display("[TB] FAIL b2b_out_valid_%0d: got %b, want 1", c, out_valid);
        end
      end
      tick();
    end
    setIdle();
    repeat (4) tick();
    testsRun++;
    if (obsQ.size() != 12) begin
      testsFailed++;
      $display("[TB] FAIL b2b_count: got %0d results, want 12", obsQ.size());
    end
    for (int i = 0; i < obsQ.size(); i++) begin
      testsRun++;
      if (obsQ[i] !== expQ[i]) begin
        testsFailed++;
        $display("[TB] FAIL b2b_result_%0d: got %h, want %h", i, obsQ[i], expQ[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]  opT [4] = '{2'd2, 2'd1, 2'd0, 2'd2};
    logic [31:0] aT [4] = '{32'h3F800000, 32'hBF800000, 32'h80000000, 32'hC0000000};
    logic [31:0] bT [4] = '{32'h40000000, 32'h3F800000, 32'h00000000, 32'hBF800000};
    int k = 0;
    int cyc = 0;
    int stabBase;
    obsQ.delete();
    expQ.delete();
    stabBase = stabilityErrors;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (k < 4) driveOp(opT[k], aT[k], bT[k], TAG_W'(10 + k));
      else in_valid = 1'b0;
      @(negedge clk);
      if (c >= 2) begin
        testsRun++;
        if (in_ready !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL bp_in_ready_low_%0d: got %b, want 0", c, in_ready);
        end
      end
      if (in_valid && in_ready) k++;
      tick();
    end
    testsRun++;
    if (k != 2) begin
      testsFailed++;
      $display("[TB] FAIL bp_accepted_while_stalled: got %0d, want 2", k);
    end
    out_ready = 1'b1;
    while (k < 4 && cyc < 20) begin
      driveOp(opT[k], aT[k], bT[k], TAG_W'(10 + k));
      @(negedge clk);
      if (in_valid && in_ready) k++;
      tick();
      cyc++;
    end
    setIdle();
    repeat (5) tick();
    testsRun++;
    if (obsQ.size() != 4 || pendQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL bp_count: got %0d results %0d pending, want 4 and 0", obsQ.size(), pendQ.size());
    end
    for (int i = 0; i < obsQ.size(); i++) begin
      testsRun++;
      if (obsQ[i] !== expQ[i] || obsQ[i].tag !== TAG_W'(10 + i)) begin
        testsFailed++;
        $display("[TB] FAIL bp_result_%0d: got %h, want %h with tag %0d", i, obsQ[i], expQ[i], 10 + i);
      end
    end
    testsRun++;
    if (stabilityErrors != stabBase) begin
      testsFailed++;
      $display("[TB] FAIL bp_hold_stable: got %0d hold violations, want 0", stabilityErrors - stabBase);
    end
  endtask

  task automatic test_flush();
    obsQ.delete();
    expQ.delete();
    out_ready = 1'b1;
    driveOp(2'd2, 32'h3F800000, 32'h40000000, TAG_W'(20));
    tick();
    driveOp(2'd1, 32'h40000000, 32'h3F800000, TAG_W'(21));
    tick();
    driveOp(2'd0, 32'h3F800000, 32'h3F800000, TAG_W'(22));
    flush = 1'b1;
    @(negedge clk);
    testsRun++;
    if (in_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL flush_in_ready: got %b, want 0", in_ready);
    end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    testsRun++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL flush_cleared: got busy %b out_valid %b, want 0/0", busy, out_valid);
    end
    driveOp(2'd2, 32'hC0000000, 32'hBF800000, TAG_W'(23));
    tick();
    setIdle();
    repeat (4) tick();
    testsRun++;
    if (obsQ.size() != 2) begin
      testsFailed++;
      $display("[TB] FAIL flush_count: got %0d results, want 2", obsQ.size());
    end else begin
      testsRun++;
      if (obsQ[0] !== expQ[0] || obsQ[0].tag !== TAG_W'(20)) begin
        testsFailed++;
        $display("[TB] FAIL flush_first: got %h, want %h tag 20", obsQ[0], expQ[0]);
      end
      testsRun++;
      if (obsQ[1] !== expQ[1] || obsQ[1].tag !== TAG_W'(23) || obsQ[1].result !== 32'd1) begin
        testsFailed++;
        $display("[TB] FAIL flush_after: got %h, want %h tag 23 res 1", obsQ[1], expQ[1]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    driveOp(2'd3, 32'h3F800000, 32'h3F800000, TAG_W'(7));
    tick();
    driveOp(2'd2, 32'h3F800000, 32'h40000000, TAG_W'(8));
    tick();
    rst = 1'b1;
    tick();
    testsRun++;
    if ({out_valid, out_result, out_tag, out_illegal, busy} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid: got valid %b res %h tag %0d ill %b busy %b, want all 0",
               out_valid, out_result, out_tag, out_illegal, busy);
    end
    rst = 1'b0;
    setIdle();
    repeat (3) tick();
    testsRun++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_discard: got valid %b busy %b, want 0/0", out_valid, busy);
    end
  endtask

  task automatic test_random();
    int accepted = 0;
    int stabBase;
    logic [31:0] a;
    obsQ.delete();
    expQ.delete();
    stabBase = stabilityErrors;
    for (int c = 0; c < 3000 && accepted < 400; c++) begin
      a = $urandom;
      driveOp(($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
              a, genOperand(a), TAG_W'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      if (in_valid && in_ready) accepted++;
      tick();
    end
    setIdle();
    out_ready = 1'b1;
    repeat (6) tick();
    testsRun++;
    if (pendQ.size() != 0 || obsQ.size() < 100) begin
      testsFailed++;
      $display("[TB] FAIL rand_drain: got %0d pending %0d results, want 0 pending and >=100 results",
               pendQ.size(), obsQ.size());
    end
    for (int i = 0; i < obsQ.size(); i++) begin
      testsRun++;
      if (obsQ[i] !== expQ[i]) begin
        testsFailed++;
        $display("[TB] FAIL rand_result_%0d: got %h, want %h", i, obsQ[i], expQ[i]);
      end
    end
    testsRun++;
    if (stabilityErrors != stabBase) begin
      testsFailed++;
      $display("[TB] FAIL rand_hold_stable: got %0d hold violations, want 0", stabilityErrors - stabBase);
    end
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    setIdle();
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
